// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard for an in-order pipeline.
// Tracks outstanding writers to x1..x31, stalls decode on RAW hazards and on
// counter saturation, and flags counter underflow as a sticky error.
// Optional build macro SB_STATS_EN adds a saturating stall-cycle counter output.
module reg_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        srst_n,
   input  logic        issue_valid,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic        rs1_used,
   input  logic        rs2_used,
   input  logic        issue_we,
   input  logic [4:0]  issue_rd,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        kill_valid,
   input  logic [4:0]  kill_rd,
   output logic        stall,
   output logic [31:0] busy,
   output logic        err
`ifdef SB_STATS_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt [32];
   logic [31:0]      r_busy;
   logic             r_err;

   logic [CNT_W-1:0] w_next [32];
   logic [31:0]      w_busy_nxt;
   logic             w_unf;
   logic             w_haz1;
   logic             w_haz2;
   logic             w_full;
   logic             w_stall;
   logic             w_accept;
   logic             w_inc;
   logic             w_dwb;
   logic             w_dkl;
   logic [CNT_W:0]   w_up;
   logic [CNT_W:0]   w_dn;

   // Hazard detection: a writeback landing this cycle on a count-of-one
   // source clears the RAW hazard because the register file writes on negedge.
   always_comb begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
      w_full = 1'b0;
      if (rs1_used && rs1 != 5'd0 && r_cnt[rs1] != '0)
         w_haz1 = !(wb_valid && wb_rd == rs1 && r_cnt[rs1] == CNT_ONE);
      if (rs2_used && rs2 != 5'd0 && r_cnt[rs2] != '0)
         w_haz2 = !(wb_valid && wb_rd == rs2 && r_cnt[rs2] == CNT_ONE);
      if (issue_we && issue_rd != 5'd0 && r_cnt[issue_rd] == CNT_MAX)
         w_full = !((wb_valid && wb_rd == issue_rd) ||
                    (kill_valid && kill_rd == issue_rd));
      w_stall  = srst_n && issue_valid && (w_haz1 || w_haz2 || w_full);
      w_accept = issue_valid && !w_stall;
   end

   assign stall = w_stall;
   assign busy  = r_busy;
   assign err   = r_err;

   // Next counter values: issue/wb/kill combine as one net delta, clamped at zero.
   always_comb begin
      w_unf      = 1'b0;
      w_busy_nxt = '0;
      w_inc      = 1'b0;
      w_dwb      = 1'b0;
      w_dkl      = 1'b0;
      w_up       = '0;
      w_dn       = '0;
      for (int r = 0; r < 32; r++) begin
         w_next[r] = '0;
         if (r != 0) begin
            w_inc = w_accept && issue_we && (issue_rd == 5'(r));
            w_dwb = wb_valid && (wb_rd == 5'(r));
            w_dkl = kill_valid && (kill_rd == 5'(r));
            w_up  = {1'b0, r_cnt[r]} + (CNT_W+1)'(w_inc);
            w_dn  = (CNT_W+1)'(w_dwb) + (CNT_W+1)'(w_dkl);
            if (w_up < w_dn) begin
               w_next[r] = '0;
               w_unf     = 1'b1;
            end else begin
               w_next[r] = CNT_W'(w_up - w_dn);
            end
            w_busy_nxt[r] = (w_next[r] != '0);
         end
      end
   end

   // Counter, busy and sticky error state; busy tracks the counters as updated.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) r_cnt[r] <= w_next[r];
         r_busy <= w_busy_nxt;
         if (w_unf) r_err <= 1'b1;
      end
   end

`ifdef SB_STATS_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of cycles in which decode was held.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n)
         r_stall_cnt <= '0;
      else if (w_stall && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (default CNT_W=2, max pending = 3).
// Inputs change on the falling edge; stall is checked 1 ns after driving,
// registered outputs are checked on the falling edge after the update.
module tb_reg_scoreboard;

   logic        clk;
   logic        srst_n;
   logic        issue_valid;
   logic [4:0]  rs1, rs2;
   logic        rs1_used, rs2_used;
   logic        issue_we;
   logic [4:0]  issue_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        kill_valid;
   logic [4:0]  kill_rd;
   logic        stall;
   logic [31:0] busy;
   logic        err;
`ifdef SB_STATS_EN
   logic [31:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   reg_scoreboard #(.CNT_W(2)) dut (
      .clk        (clk),
      .srst_n     (srst_n),
      .issue_valid(issue_valid),
      .rs1        (rs1),
      .rs2        (rs2),
      .rs1_used   (rs1_used),
      .rs2_used   (rs2_used),
      .issue_we   (issue_we),
      .issue_rd   (issue_rd),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .kill_valid (kill_valid),
      .kill_rd    (kill_rd),
      .stall      (stall),
      .busy       (busy),
      .err        (err)
`ifdef SB_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic iv, input logic [4:0] s1, input logic u1,
                      input logic [4:0] s2, input logic u2,
                      input logic we, input logic [4:0] rd,
                      input logic wv, input logic [4:0] wr,
                      input logic kv, input logic [4:0] kr);
      issue_valid = iv; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
      issue_we = we; issue_rd = rd; wb_valid = wv; wb_rd = wr;
      kill_valid = kv; kill_rd = kr;
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      srst_n = 1'b0;
      // Reset state, with an issue presented that must not stall or register
      drv(1, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      idle();
      srst_n = 1'b1;
      tick();
      chk("post_rst_busy", busy, 32'd0);

      // RAW on x5
      drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      chk("raw_issue_rd5", {31'd0, stall}, 32'd0);
      tick();
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_stall_1", {31'd0, stall}, 32'd1);
      tick();
      chk("raw_busy5", busy, 32'h0000_0020);
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_stall_2", {31'd0, stall}, 32'd1);
      tick();
      drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
      chk("raw_wb_bypass", {31'd0, stall}, 32'd0);
      tick();
      idle();
      tick();
      chk("raw_busy_clear", busy, 32'd0);

      // x0 never counts
      drv(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("x0_issue", {31'd0, stall}, 32'd0);
      tick();
      drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("x0_read", {31'd0, stall}, 32'd0);
      tick();
      idle();
      tick();
      chk("x0_busy", busy, 32'd0);

      // WAW saturation on x9
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
         chk($sformatf("waw_issue%0d", i), {31'd0, stall}, 32'd0);
         tick();
      end
      chk("waw_busy9", busy, 32'h0000_0200);
      drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
      chk("waw_full_stall", {31'd0, stall}, 32'd1);
      tick();
      drv(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0);
      chk("waw_full_wb", {31'd0, stall}, 32'd0);
      tick();
      drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
      chk("waw_still_full", {31'd0, stall}, 32'd1);
      tick();
`ifdef SB_STATS_EN
      chk("stats_4", stall_cnt, 32'd4);
`endif
      // drain x9: 3 -> 2
      drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      tick();
      // count 2 with wb: hazard persists
      drv(1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0);
      chk("cnt2_wb_stall", {31'd0, stall}, 32'd1);
      tick();
      // count 1 with wb: bypass on rs2
      drv(1, 0, 0, 9, 1, 0, 0, 1, 9, 0, 0);
      chk("cnt1_wb_rs2", {31'd0, stall}, 32'd0);
      tick();
      idle();
      tick();
      chk("waw_drained", busy, 32'd0);

      // Simultaneous issue + wb on x7
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
      tick();
      drv(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
      chk("sim_stall", {31'd0, stall}, 32'd0);
      tick();
      idle();
      tick();
      chk("sim_busy7", busy, 32'h0000_0080);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      tick();
      idle();
      tick();
      chk("sim_busy7_clr", busy, 32'd0);

      // Two pending on x3 released by wb + kill together; index 0 ignored
      drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      tick();
      drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
      tick();
      idle();
      tick();
      chk("wbkill_busy", busy, 32'd0);
      chk("wbkill_err", {31'd0, err}, 32'd0);

      // Underflow on x12
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
      tick();
      idle();
      tick();
      chk("unf_err", {31'd0, err}, 32'd1);
      chk("unf_busy", busy, 32'd0);
      drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      chk("unf_err_sticky", {31'd0, err}, 32'd1);
      chk("pre_rst_busy4", busy, 32'h0000_0010);

      // Async reset pulse mid-cycle with a coinciding issue that must drop
      drv(1, 4, 1, 0, 0, 1, 4, 0, 0, 0, 0);
      chk("pre_rst_stall", {31'd0, stall}, 32'd1);
      #1;
      srst_n = 1'b0;
      #1;
      chk("arst_err", {31'd0, err}, 32'd0);
      chk("arst_busy", busy, 32'd0);
      chk("arst_stall", {31'd0, stall}, 32'd0);
      drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("arst_drop", busy, 32'd0);
      idle();
      srst_n = 1'b1;
`ifdef SB_STATS_EN
      chk("stats_rst", stall_cnt, 32'd0);
`endif
      // First edge after release updates
      drv(1, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      chk("post_rel_busy20", busy, 32'h0010_0000);
      chk("post_rel_err", {31'd0, err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, meaning the width of the per-register pending-write counter (max pending = 2^CNT_W-1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port srst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port issue_valid, input, 1, the decode stage presenting an instruction.
REQ-005 SHALL have port rs1/rs2, input, 5 each, the source register indices sent to the register file read ports.
REQ-006 SHALL have port rs1_used/rs2_used, input, 1 each, meaning the source is actually read.
REQ-007 SHALL have port issue_we/issue_rd, input, 1/5, the destination write intent of the issuing instruction.
REQ-008 SHALL have port wb_valid/wb_rd, input, 1/5, the writeback that drives register file WE3/A3 this cycle.
REQ-009 SHALL have port kill_valid/kill_rd, input, 1/5, a squashed in-flight writer releasing its destination.
REQ-010 SHALL have port stall, output, 1, holding decode (no issue this cycle).
REQ-011 SHALL have port busy, output, 32, where bit n = register n has a nonzero pending count.
REQ-012 SHALL have port err, output, 1, a sticky counter underflow flag.

Function
REQ-013 SHALL keep one CNT_W-bit pending counter per register 1..31; register 0 SHALL never count and busy[0] SHALL be constant 0.
REQ-014 SHALL assert stall combinationally when issue_valid and, for a used source rsX != 0, cnt[rsX] > 0, unless wb_valid && wb_rd==rsX && cnt[rsX]==1 (the register file writes on negedge, so a same-cycle writeback resolves the hazard).
REQ-015 SHALL also assert stall when issue_valid && issue_we && issue_rd!=0 && cnt[issue_rd] equals max and no same-cycle wb/kill frees that register.
REQ-016 SHALL treat the issue as accepted when issue_valid && !stall; stall SHALL be 0 when issue_valid is 0.
REQ-017 SHALL, on each rising edge, update cnt[r] by: +1 for an accepted issue with issue_we and issue_rd==r; -1 for wb_valid with wb_rd==r; -1 for kill_valid with kill_rd==r; all three SHALL combine as a net delta in one cycle.
REQ-018 SHALL ignore indices of 0 for wb, kill and issue updates.
REQ-019 SHALL clamp a net decrement below zero at zero and set err, which SHALL stay at 1 until reset.
REQ-020 SHALL never exceed the maximum, because REQ-015 guarantees that.
REQ-021 SHALL register busy directly from the counters, so busy changes one cycle after the causing event.

Reset
REQ-022 SHALL, while srst_n is 0, clear all counters, busy=0, err=0 and stall=0, regardless of clk.
REQ-023 SHALL drop any issue, wb or kill coinciding with reset assertion, and SHALL allow the first update on the first rising edge after srst_n rises.

Configuration
REQ-024 SHALL, when macro SB_STATS_EN is defined, add output stall_cnt (32 bits), incremented each cycle stall is 1, saturating at all-ones, and cleared by reset.
REQ-025 SHALL, without SB_STATS_EN, have no stall_cnt port and no associated logic, with otherwise identical behaviour.

Verification
REQ-026 SHALL cover RAW: issue rd=5 (accepted), next cycle issue rs1=5 used -> stall=1; cycle with wb_rd=5 -> stall=0 and issue accepted; busy[5] = 0 afterwards.
REQ-027 SHALL cover x0: issue rd=0 then rs1=0 used -> stall never asserted and busy stays 0.
REQ-028 SHALL cover WAW saturation with CNT_W=2: three accepted issues rd=9, then a fourth -> stall=1; same cycle wb_rd=9 -> accepted and cnt[9] stays 3.
REQ-029 SHALL cover simultaneous events: cnt[7]=1, accepted issue rd=7 plus wb_rd=7 in one cycle -> cnt[7]=1 and busy[7]=1.
REQ-030 SHALL cover underflow: kill_rd=12 with cnt[12]=0 -> cnt stays 0 and err=1 held; an async srst_n pulse mid-cycle -> err=0 and busy=0 immediately.
REQ-031 SHALL cover stats with SB_STATS_EN: 4 stalled cycles -> stall_cnt=4; without the macro, the build has no stall_cnt port.
